// File: rtl/router_pkg.sv
// Shared types and header helpers for the router packet source.
// The header byte packs the payload length above the destination port.
package router_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      PAYLOAD = 2'd2,
      PARITY  = 2'd3
   } tx_state_t;

   localparam int MAX_LEN  = 63;
   localparam int LEN_MSB  = 7;
   localparam int LEN_LSB  = 2;
   localparam int ADDR_MSB = 1;
   localparam int ADDR_LSB = 0;
   localparam logic [1:0] ILLEGAL_ADDR = 2'd3;

   function automatic logic [7:0] make_header(input logic [5:0] len, input logic [1:0] addr);
      logic [7:0] hdr;
      hdr = 8'h00;
      hdr[LEN_MSB:LEN_LSB]   = len;
      hdr[ADDR_MSB:ADDR_LSB] = addr;
      return hdr;
   endfunction

   function automatic logic cmd_is_illegal(input logic [5:0] len, input logic [1:0] addr);
      return (len == 6'd0) || (addr == ILLEGAL_ADDR);
   endfunction

endpackage

// File: rtl/router_tx_fifo.sv
// Synchronous show-ahead byte FIFO: rdata always presents the head entry.
// The RAM read is registered at the next read pointer, with a bypass for same-cycle writes.
module router_tx_fifo
   import router_pkg::*;
#(
   parameter int FIFO_DEPTH = 64,
   parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [7:0]       wdata,
   input  logic             pop,
   output logic [7:0]       rdata,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_next;
   logic [LVL_W-1:0] level_reg;
   logic [7:0]       rdata_reg;
   logic             push_ok;
   logic             pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (level_reg == LVL_W'(FIFO_DEPTH));
   assign empty   = (level_reg == '0);
   // A full buffer refuses pushes even while popping, so pl_ready reopens a cycle later.
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rd_ptr_next = pop_ok ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;

   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         rdata_reg  <= 8'h00;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         end
         rd_ptr_reg <= rd_ptr_next;
         level_reg  <= level_reg + LVL_W'(push_ok) - LVL_W'(pop_ok);
         // The entry being written lands where the head will be next, so forward it.
         if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
            rdata_reg <= wdata;
         end else begin
            rdata_reg <= mem[rd_ptr_next];
         end
      end
   end

   assign rdata = rdata_reg;
   assign level = level_reg;

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the router input port: header, buffered payload, even-XOR parity byte.
// Honors the router busy stall by holding data_out/pkt_valid and suspending pops.
module router_pkt_tx
   import router_pkg::*;
#(
   parameter int FIFO_DEPTH = 64,
   parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] pl_data,
   input  logic       pl_valid,
   output logic       pl_ready,
   input  logic [1:0] cmd_addr,
   input  logic [5:0] cmd_len,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       inject_err,
   input  logic       busy,
   output logic [7:0] data_out,
   output logic       pkt_valid,
   output logic       pkt_done,
   output logic       cmd_err
);

   localparam int REM_W = $clog2(MAX_LEN + 1);

   tx_state_t        state_reg, state_next;
   logic [REM_W-1:0] rem_reg, rem_next;
   logic [7:0]       par_reg, par_next;
   logic [7:0]       data_out_reg, data_out_next;
   logic             pkt_valid_reg, pkt_valid_next;
   logic             pkt_done_reg, pkt_done_next;
   logic             cmd_err_reg, cmd_err_next;
   logic             inj_reg, inj_next;
   logic             fifo_pop;
   logic             fifo_push;
   logic             fifo_full;
   logic             fifo_empty;
   logic [7:0]       fifo_rdata;
   logic [LVL_W-1:0] fifo_level;
   logic             cmd_illegal;
   logic [7:0]       cmd_header;

   router_tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .LVL_W      (LVL_W)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .wdata (pl_data),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign pl_ready    = ~fifo_full;
   assign fifo_push   = pl_valid & pl_ready;
   assign cmd_illegal = cmd_is_illegal(cmd_len, cmd_addr);
   assign cmd_header  = make_header(cmd_len, cmd_addr);
   // Legal commands wait until the whole payload is already buffered, so no mid-packet underflow.
   assign cmd_ready   = ~reset & (state_reg == IDLE) &
                        (cmd_illegal | (fifo_level >= LVL_W'(cmd_len)));

   always_comb begin
      state_next     = state_reg;
      rem_next       = rem_reg;
      par_next       = par_reg;
      data_out_next  = data_out_reg;
      pkt_valid_next = pkt_valid_reg;
      pkt_done_next  = 1'b0;
      cmd_err_next   = 1'b0;
      inj_next       = inj_reg;
      fifo_pop       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               if (cmd_illegal) begin
                  cmd_err_next = 1'b1;
               end else begin
                  data_out_next  = cmd_header;
                  pkt_valid_next = 1'b1;
                  par_next       = cmd_header;
                  rem_next       = cmd_len;
                  inj_next       = inject_err;
                  state_next     = HEADER;
               end
            end
         end
         HEADER, PAYLOAD: begin
            if (!busy) begin
               if ((state_reg == HEADER) || (rem_reg != '0)) begin
                  fifo_pop      = 1'b1;
                  data_out_next = fifo_rdata;
                  par_next      = par_reg ^ fifo_rdata;
                  rem_next      = rem_reg - 1'b1;
                  state_next    = PAYLOAD;
               end else begin
                  data_out_next  = par_reg ^ {7'b0, inj_reg};
                  pkt_valid_next = 1'b0;
                  state_next     = PARITY;
               end
            end
         end
         PARITY: begin
            if (!busy) begin
               data_out_next = 8'h00;
               pkt_done_next = 1'b1;
               state_next    = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= IDLE;
         rem_reg       <= '0;
         par_reg       <= 8'h00;
         data_out_reg  <= 8'h00;
         pkt_valid_reg <= 1'b0;
         pkt_done_reg  <= 1'b0;
         cmd_err_reg   <= 1'b0;
         inj_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         rem_reg       <= rem_next;
         par_reg       <= par_next;
         data_out_reg  <= data_out_next;
         pkt_valid_reg <= pkt_valid_next;
         pkt_done_reg  <= pkt_done_next;
         cmd_err_reg   <= cmd_err_next;
         inj_reg       <= inj_next;
      end
   end

   assign data_out  = data_out_reg;
   assign pkt_valid = pkt_valid_reg;
   assign pkt_done  = pkt_done_reg;
   assign cmd_err   = cmd_err_reg;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx with a queue-based packet model checked every cycle.
module tb_router_pkt_tx;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] pl_data;
   logic       pl_valid;
   logic       pl_ready;
   logic [1:0] cmd_addr;
   logic [5:0] cmd_len;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       inject_err;
   logic       busy;
   logic [7:0] data_out;
   logic       pkt_valid;
   logic       pkt_done;
   logic       cmd_err;

   always #5 clock = ~clock;

   router_pkt_tx dut (
      .clock      (clock),
      .reset      (reset),
      .pl_data    (pl_data),
      .pl_valid   (pl_valid),
      .pl_ready   (pl_ready),
      .cmd_addr   (cmd_addr),
      .cmd_len    (cmd_len),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .inject_err (inject_err),
      .busy       (busy),
      .data_out   (data_out),
      .pkt_valid  (pkt_valid),
      .pkt_done   (pkt_done),
      .cmd_err    (cmd_err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Model: buffer contents as a queue, and each accepted packet as its full byte list.
   logic [7:0] mq[$];
   logic [7:0] m_pkt[$];
   bit         m_active = 1'b0;
   int         m_pos = 0;
   int         m_len = 0;
   bit         m_done = 1'b0;
   bit         m_err = 1'b0;

   function automatic bit m_illegal();
      return (cmd_len == 6'd0) || (cmd_addr == 2'd3);
   endfunction

   function automatic bit m_cmd_ready();
      if (reset || m_active) return 1'b0;
      return m_illegal() || (mq.size() >= int'(cmd_len));
   endfunction

   always @(posedge clock) begin
      bit         rdy_pl;
      bit         rdy_cmd;
      logic [7:0] hdr;
      logic [7:0] par;
      logic [7:0] junk;
      rdy_pl  = (mq.size() < 64);
      rdy_cmd = m_cmd_ready();
      m_done  = 1'b0;
      m_err   = 1'b0;
      if (reset) begin
         mq.delete();
         m_pkt.delete();
         m_active = 1'b0;
      end else begin
         if (m_active && !busy) begin
            if (m_pos == m_len + 1) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end else begin
               if (m_pos < m_len) junk = mq.pop_front();
               m_pos++;
            end
         end
         if (pl_valid && rdy_pl) mq.push_back(pl_data);
         if (cmd_valid && rdy_cmd) begin
            if (m_illegal()) begin
               m_err = 1'b1;
            end else begin
               hdr = {cmd_len, cmd_addr};
               par = hdr;
               m_pkt.delete();
               m_pkt.push_back(hdr);
               for (int i = 0; i < int'(cmd_len); i++) begin
                  m_pkt.push_back(mq[i]);
                  par = par ^ mq[i];
               end
               m_pkt.push_back(par ^ {7'b0, inject_err});
               m_len    = int'(cmd_len);
               m_pos    = 0;
               m_active = 1'b1;
            end
         end
      end
   end

   bit         cmp_en = 1'b0;
   logic [7:0] log_q[$];
   int         n_err_seen = 0;
   int         n22 = 0;

   always @(negedge clock) begin
      if (cmp_en) begin
         chk("pl_ready", pl_ready, mq.size() < 64);
         chk("cmd_ready", cmd_ready, m_cmd_ready());
         chk("pkt_done", pkt_done, m_done);
         chk("cmd_err", cmd_err, m_err);
         if (m_active) begin
            chk("data_out", data_out, m_pkt[m_pos]);
            chk("pkt_valid", pkt_valid, m_pos <= m_len);
         end else begin
            chk("idle_data_out", data_out, 8'h00);
            chk("idle_pkt_valid", pkt_valid, 1'b0);
         end
         if (!busy && (pkt_valid || data_out != 8'h00)) log_q.push_back(data_out);
         if (cmd_err) n_err_seen++;
         if (pkt_valid && data_out == 8'h22) n22++;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      pl_valid = 1'b1;
      pl_data  = b;
      tick();
      pl_valid = 1'b0;
   endtask

   task automatic send_cmd(input logic [1:0] a, input logic [5:0] l, input logic inj);
      bit ok;
      cmd_addr   = a;
      cmd_len    = l;
      inject_err = inj;
      cmd_valid  = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("cmd_accepted", ok, 1'b1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (pkt_done) begin
            seen = 1'b1;
            break;
         end
      end
      chk("pkt_done_seen", seen, 1'b1);
      tick();
   endtask

   task automatic chk_log(input string nm, input logic [7:0] e[$]);
      chk({nm, "_len"}, log_q.size(), e.size());
      for (int i = 0; i < e.size() && i < log_q.size(); i++) begin
         chk($sformatf("%s_b%0d", nm, i), log_q[i], e[i]);
      end
   endtask

   initial begin
      logic [7:0] e[$];
      logic [7:0] x;
      bit         found;
      reset = 1'b1; pl_data = 8'h00; pl_valid = 1'b0; cmd_addr = 2'd0; cmd_len = 6'd0;
      cmd_valid = 1'b0; inject_err = 1'b0; busy = 1'b0;
      tick();
      cmp_en = 1'b1;
      tick();
      chk("rst_data_out", data_out, 8'h00);
      chk("rst_pkt_valid", pkt_valid, 1'b0);
      chk("rst_cmd_ready", cmd_ready, 1'b0);
      reset = 1'b0;
      tick();

      // 1: plain packet
      log_q.delete();
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
      send_cmd(2'd1, 6'd3, 1'b0);
      wait_done();
      e = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
      chk_log("t1", e);
      $display("t1 plain packet: %0d bytes logged", log_q.size());

      // 2: busy stall on byte 22
      log_q.delete();
      n22 = 0;
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
      send_cmd(2'd1, 6'd3, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (pkt_valid && data_out == 8'h22) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk("t2_found22", found, 1'b1);
      busy = 1'b1;
      repeat (3) tick();
      busy = 1'b0;
      wait_done();
      e = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
      chk_log("t2", e);
      chk("t2_hold22", n22, 4);
      $display("t2 busy stall: byte 22 visible %0d cycles", n22);

      // 3: injected parity error
      log_q.delete();
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
      send_cmd(2'd1, 6'd3, 1'b1);
      wait_done();
      e = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C};
      chk_log("t3", e);
      x = 8'h00;
      for (int i = 0; i + 1 < log_q.size(); i++) x = x ^ log_q[i];
      chk("t3_router_err", (log_q.size() > 0) && (x != log_q[log_q.size()-1]), 1'b1);
      $display("t3 inject_err: router recomputed parity %0h", x);

      // 4: illegal commands leave the buffer alone
      log_q.delete();
      n_err_seen = 0;
      push_byte(8'hA1); push_byte(8'hA2);
      send_cmd(2'd1, 6'd0, 1'b0);
      send_cmd(2'd3, 6'd2, 1'b0);
      tick(); tick();
      chk("t4_err_pulses", n_err_seen, 2);
      chk("t4_no_bytes", log_q.size(), 0);
      send_cmd(2'd2, 6'd2, 1'b0);
      wait_done();
      e = '{8'h0A, 8'hA1, 8'hA2, 8'h09};
      chk_log("t4", e);
      $display("t4 illegal cmds: %0d cmd_err pulses", n_err_seen);

      // 5: command waits for payload
      log_q.delete();
      push_byte(8'h51); push_byte(8'h52); push_byte(8'h53);
      cmd_addr = 2'd0; cmd_len = 6'd5; inject_err = 1'b0; cmd_valid = 1'b1;
      @(negedge clock);
      chk("t5_not_ready", cmd_ready, 1'b0);
      @(posedge clock); #1;
      push_byte(8'h54); push_byte(8'h55);
      @(negedge clock);
      chk("t5_ready", cmd_ready, 1'b1);
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      wait_done();
      e = '{8'h14, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h45};
      chk_log("t5", e);
      $display("t5 deferred cmd: %0d bytes logged", log_q.size());

      // 6: fill, long packet, reset mid-payload
      for (int i = 0; i < 64; i++) push_byte(8'h80 + 8'(i));
      @(negedge clock);
      chk("t6_full", pl_ready, 1'b0);
      @(posedge clock); #1;
      push_byte(8'hFF);
      send_cmd(2'd2, 6'd63, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (pkt_valid && data_out == 8'h89) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk("t6_reach_b10", found, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      cmd_addr = 2'd0; cmd_len = 6'd1;
      #1;
      chk("t6_rst_data_out", data_out, 8'h00);
      chk("t6_rst_pkt_valid", pkt_valid, 1'b0);
      chk("t6_rst_pl_ready", pl_ready, 1'b1);
      chk("t6_rst_level0", cmd_ready, 1'b0);
      tick();
      log_q.delete();
      push_byte(8'h5A);
      send_cmd(2'd0, 6'd1, 1'b0);
      wait_done();
      e = '{8'h04, 8'h5A, 8'h5E};
      chk_log("t6", e);
      $display("t6 reset mid-packet: post-reset packet %0d bytes", log_q.size());

      tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
